// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter: widths, the
// hard-wired zero register and the arbiter state encoding.
package regfile_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;   // wide enough for a starvation limit of 15

   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef enum logic {
      PRIO0  = 1'b0,   // pipeline writeback wins a tie
      FORCE1 = 1'b1    // host/debug loader has starved, it wins the tie
   } arb_state_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the two writer handshakes, the register-file write port and the
// decode-stage hazard lookup. The master side is the environment (writers,
// register file, decode); the slave side is the arbiter.
interface regfile_write_arbiter_if #(
   parameter int ADDR_W = regfile_pkg::ADDR_W,
   parameter int DATA_W = regfile_pkg::DATA_W
);

   // Port 0: pipeline writeback
   logic              p0_valid;
   logic              p0_ready;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_data;

   // Port 1: host/debug loader
   logic              p1_valid;
   logic              p1_ready;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_data;

   // Register file write port
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;

   // Decode-stage pending-write lookup
   logic [ADDR_W-1:0] rd_addr_1;
   logic [ADDR_W-1:0] rd_addr_2;
   logic              rd_hazard_1;
   logic              rd_hazard_2;

   modport master (
      output p0_valid, p0_addr, p0_data,
      output p1_valid, p1_addr, p1_data,
      output rd_addr_1, rd_addr_2,
      input  p0_ready, p1_ready,
      input  rf_we, rf_waddr, rf_wdata,
      input  rd_hazard_1, rd_hazard_2
   );

   modport slave (
      input  p0_valid, p0_addr, p0_data,
      input  p1_valid, p1_addr, p1_data,
      input  rd_addr_1, rd_addr_2,
      output p0_ready, p1_ready,
      output rf_we, rf_waddr, rf_wdata,
      output rd_hazard_1, rd_hazard_2
   );

endinterface

// File: rtl/regfile_write_arbiter_wr_hold_slot.sv
// One-entry holding register for a single writer. The slot accepts a new
// entry whenever it is empty or is being drained by a grant this cycle, so a
// port can refill in the same cycle it drains.
module wr_hold_slot #(
   parameter int ADDR_W = regfile_pkg::ADDR_W,
   parameter int DATA_W = regfile_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_grant,
   output logic              o_hold_v,
   output logic [ADDR_W-1:0] o_hold_addr,
   output logic [DATA_W-1:0] o_hold_data
);

   logic              r_en;
   logic              r_hold_v;
   logic [ADDR_W-1:0] r_hold_addr;
   logic [DATA_W-1:0] r_hold_data;
   logic              w_take;

   // r_en keeps ready low during reset and lifts it on the first clock after.
   assign o_ready = r_en && (!r_hold_v || i_grant);
   assign w_take  = i_valid && o_ready;

   // Occupancy flag and post-reset run enable.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en     <= 1'b0;
         r_hold_v <= 1'b0;
      end else begin
         r_en <= 1'b1;
         if (w_take)
            r_hold_v <= 1'b1;
         else if (i_grant)
            r_hold_v <= 1'b0;
      end
   end

   // Payload capture on each accepted transfer.
   // NOTE: the payload is deliberately not reset; every consumer qualifies it
   // with r_hold_v, so clearing the valid bit is enough to discard an entry.
   always_ff @(posedge clk) begin
      if (w_take) begin
         r_hold_addr <= i_addr;
         r_hold_data <= i_data;
      end
   end

   assign o_hold_v    = r_hold_v;
   assign o_hold_addr = r_hold_addr;
   assign o_hold_data = r_hold_data;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between pipeline writeback
// (port 0) and the host/debug loader (port 1). Fixed priority to port 0 with
// a starvation counter that forces port 1 through, a registered write port,
// and a combinational pending-write scoreboard for decode.
import regfile_pkg::*;

module regfile_write_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = regfile_pkg::ADDR_W,
   parameter int DATA_W       = regfile_pkg::DATA_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   regfile_write_arbiter_if.slave  bus
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
   localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

   logic              w_ready0, w_ready1;
   logic              w_hv0, w_hv1;
   logic [ADDR_W-1:0] w_ha0, w_ha1;
   logic [DATA_W-1:0] w_hd0, w_hd1;
   logic              w_grant0, w_grant1;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_data;

   arb_state_t        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;

   wr_hold_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_valid     (bus.p0_valid),
      .o_ready     (w_ready0),
      .i_addr      (bus.p0_addr),
      .i_data      (bus.p0_data),
      .i_grant     (w_grant0),
      .o_hold_v    (w_hv0),
      .o_hold_addr (w_ha0),
      .o_hold_data (w_hd0)
   );

   wr_hold_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_valid     (bus.p1_valid),
      .o_ready     (w_ready1),
      .i_addr      (bus.p1_addr),
      .i_data      (bus.p1_data),
      .i_grant     (w_grant1),
      .o_hold_v    (w_hv1),
      .o_hold_addr (w_ha1),
      .o_hold_data (w_hd1)
   );

   // Grant one occupied slot; a tie goes to port 0 unless port 1 has starved.
   // NOTE: every output of a combinational block gets a default first, so no
   // path through the if/else can leave a value held and infer a latch.
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (w_hv0 && (!w_hv1 || r_state == PRIO0))
         w_grant0 = 1'b1;
      else if (w_hv1)
         w_grant1 = 1'b1;
   end

   assign w_sel_addr = w_grant1 ? w_ha1 : w_ha0;
   assign w_sel_data = w_grant1 ? w_hd1 : w_hd0;

   // Starvation counter and PRIO0/FORCE1 state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= PRIO0;
         r_cnt   <= '0;
      end else begin
         if (w_hv1 && !w_grant1) begin
            if (r_cnt != LIMIT)
               r_cnt <= r_cnt + 1'b1;
         end else begin
            r_cnt <= '0;
         end

         case (r_state)
            PRIO0:   if (r_cnt == LIMIT && !w_grant1) r_state <= FORCE1;
            FORCE1:  if (w_grant1)                    r_state <= PRIO0;
            default: r_state <= PRIO0;
         endcase
      end
   end

   // Registered register-file write port; writes to register 0 are swallowed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else if (w_grant0 || w_grant1) begin
         r_we    <= (w_sel_addr != ZERO);
         r_waddr <= w_sel_addr;
         r_wdata <= w_sel_data;
      end else begin
         r_we    <= 1'b0;
      end
   end

   assign bus.p0_ready = w_ready0;
   assign bus.p1_ready = w_ready1;
   assign bus.rf_we    = r_we;
   assign bus.rf_waddr = r_waddr;
   assign bus.rf_wdata = r_wdata;

   // A read address is hazardous if any held or outgoing write targets it.
   assign bus.rd_hazard_1 = (bus.rd_addr_1 != ZERO) &&
                            ((w_hv0 && w_ha0 == bus.rd_addr_1) ||
                             (w_hv1 && w_ha1 == bus.rd_addr_1) ||
                             (r_we  && r_waddr == bus.rd_addr_1));

   assign bus.rd_hazard_2 = (bus.rd_addr_2 != ZERO) &&
                            ((w_hv0 && w_ha0 == bus.rd_addr_2) ||
                             (w_hv1 && w_ha1 == bus.rd_addr_2) ||
                             (r_we  && r_waddr == bus.rd_addr_2));

endmodule
